// File: rtl/rep_win_pkg.sv
// Shared types for the repetition-window checker: FSM state encoding,
// per-window result bundle and the delay-counter width.
package rep_win_pkg;

  localparam int DLY_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    COUNT,
    REPORT
  } rep_win_state_t;

  typedef struct packed {
    logic pass;
    logic fail_qual;
    logic fail_consec;
  } rep_win_result_t;

endpackage

// File: rtl/rep_edge_det.sv
// Registers the window input and emits single-cycle rise/fall pulses
// derived from the current sample against the registered one.
module rep_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic rise,
  output logic fall
);

  logic sig_d, sig_q;

  always_comb begin
    sig_d = sig;
  end

  always_ff @(posedge clk) begin
    if (rst) sig_q <= 1'b0;
    else     sig_q <= sig_d;
  end

  assign rise = sig  & ~sig_q;
  assign fall = ~sig & sig_q;

endmodule

// File: rtl/rep_window_checker.sv
// Counts qualified events inside a win-delimited window and reports the verdict.
// Define REP_WIN_CONSEC_CHK_EN to flag events on two consecutive counting cycles.
module rep_window_checker
  import rep_win_pkg::*;
#(
  parameter int CNT_W     = 4,
  parameter int EXP_CNT   = 3,
  parameter int START_DLY = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             win,
  input  logic             evt,
  input  logic             qual,
  output logic             busy,
  output logic [CNT_W-1:0] count,
  output logic             done,
  output logic             pass,
  output logic             fail_qual,
  output logic             fail_consec,
  output logic             ovf
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic win_rise, win_fall;

  rep_win_state_t  state_d, state_q;
  logic [CNT_W-1:0] count_d, count_q;
  logic [DLY_W-1:0] dly_d, dly_q;
  logic             fail_qual_d, fail_qual_q;
  logic             ovf_d, ovf_q;
  rep_win_result_t  res;

  rep_edge_det u_edge (
    .clk  (clk),
    .rst  (rst),
    .sig  (win),
    .rise (win_rise),
    .fall (win_fall)
  );

`ifdef REP_WIN_CONSEC_CHK_EN
  logic prev_evt_d, prev_evt_q;
  logic fail_consec_d, fail_consec_q;
`endif

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    dly_d       = dly_q;
    fail_qual_d = fail_qual_q;
    ovf_d       = ovf_q;
`ifdef REP_WIN_CONSEC_CHK_EN
    prev_evt_d    = prev_evt_q;
    fail_consec_d = fail_consec_q;
`endif

    case (state_q)
      DELAY: begin
        if (!qual) fail_qual_d = 1'b1;
        if (win_fall)                state_d = REPORT;
        else if (dly_q <= DLY_W'(1)) state_d = COUNT;
        else                         dly_d   = dly_q - DLY_W'(1);
      end
      COUNT: begin
        if (!qual) fail_qual_d = 1'b1;
        if (win_fall) begin
          state_d = REPORT;
        end else begin
          // ovf marks an event lost to saturation, not merely reaching the max
          if (evt) begin
            if (count_q == CNT_MAX) ovf_d   = 1'b1;
            else                    count_d = count_q + CNT_W'(1);
          end
`ifdef REP_WIN_CONSEC_CHK_EN
          if (evt && prev_evt_q) fail_consec_d = 1'b1;
          prev_evt_d = evt;
`endif
        end
      end
      REPORT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // An open seen in REPORT restarts immediately so back-to-back windows survive
    if ((state_q == IDLE || state_q == REPORT) && win_rise) begin
      count_d     = '0;
      fail_qual_d = 1'b0;
      dly_d       = DLY_W'(START_DLY);
      state_d     = (START_DLY == 0) ? COUNT : DELAY;
`ifdef REP_WIN_CONSEC_CHK_EN
      prev_evt_d    = 1'b0;
      fail_consec_d = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      count_q     <= '0;
      dly_q       <= '0;
      fail_qual_q <= 1'b0;
      ovf_q       <= 1'b0;
`ifdef REP_WIN_CONSEC_CHK_EN
      prev_evt_q    <= 1'b0;
      fail_consec_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      dly_q       <= dly_d;
      fail_qual_q <= fail_qual_d;
      ovf_q       <= ovf_d;
`ifdef REP_WIN_CONSEC_CHK_EN
      prev_evt_q    <= prev_evt_d;
      fail_consec_q <= fail_consec_d;
`endif
    end
  end

  always_comb begin
    res = '0;
    if (state_q == REPORT) begin
      res.fail_qual = fail_qual_q;
`ifdef REP_WIN_CONSEC_CHK_EN
      res.fail_consec = fail_consec_q;
`endif
      res.pass = (count_q == CNT_W'(EXP_CNT)) && !res.fail_qual && !res.fail_consec;
    end
  end

  assign busy        = (state_q == DELAY) || (state_q == COUNT);
  assign done        = (state_q == REPORT);
  assign count       = count_q;
  assign pass        = res.pass;
  assign fail_qual   = res.fail_qual;
  assign fail_consec = res.fail_consec;
  assign ovf         = ovf_q;

endmodule

// File: tb/tb_rep_window_checker.sv
// Scoreboard bench for rep_window_checker: a default instance and a CNT_W=2
// instance share stimulus; per-instance monitors check each done pulse.
module tb_rep_window_checker;

  typedef struct {
    int   count;
    logic pass;
    logic fail_qual;
    logic fail_consec;
    logic ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst, win, evt, qual;

  logic       busy_a, done_a, pass_a, fq_a, fc_a, ovf_a;
  logic [3:0] count_a;
  logic       busy_b, done_b, pass_b, fq_b, fc_b, ovf_b;
  logic [1:0] count_b;

  exp_t exp_a[$];
  exp_t exp_b[$];

  int checks = 0;
  int errors = 0;

`ifdef REP_WIN_CONSEC_CHK_EN
  localparam logic CONSEC_EN = 1'b1;
`else
  localparam logic CONSEC_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  rep_window_checker dut_a (
    .clk(clk), .rst(rst), .win(win), .evt(evt), .qual(qual),
    .busy(busy_a), .count(count_a), .done(done_a), .pass(pass_a),
    .fail_qual(fq_a), .fail_consec(fc_a), .ovf(ovf_a)
  );

  rep_window_checker #(.CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .win(win), .evt(evt), .qual(qual),
    .busy(busy_b), .count(count_b), .done(done_b), .pass(pass_b),
    .fail_qual(fq_b), .fail_consec(fc_b), .ovf(ovf_b)
  );

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  function automatic exp_t mk(input int c, input logic p, input logic fq,
                              input logic fc, input logic o);
    exp_t e;
    e.count = c; e.pass = p; e.fail_qual = fq; e.fail_consec = fc; e.ovf = o;
    return e;
  endfunction

  task automatic applyStimulus(input logic w, input logic e, input logic q);
    win = w; evt = e; qual = q;
    @(posedge clk);
    #1;
  endtask

  // Cycle 1 opens the window, cycle close_cyc drops win; expected results are
  // queued just before the closing edge.
  task automatic runWindow(input int close_cyc, input logic [31:0] evt_mask,
                           input logic [31:0] qlow_mask, input exp_t ea, input exp_t eb);
    for (int c = 1; c <= close_cyc; c++) begin
      if (c == close_cyc) begin
        exp_a.push_back(ea);
        exp_b.push_back(eb);
        applyStimulus(1'b0, evt_mask[c], !qlow_mask[c]);
      end else begin
        applyStimulus(1'b1, evt_mask[c], !qlow_mask[c]);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b1);
  endtask

  always @(negedge clk) begin
    if (done_a) begin
      if (exp_a.size() == 0) begin
        checkOutput("unexpected_done_a", 1, 0);
      end else begin
        exp_t e;
        e = exp_a.pop_front();
        checkOutput("a_count", int'(count_a), e.count);
        checkOutput("a_pass", int'(pass_a), int'(e.pass));
        checkOutput("a_fail_qual", int'(fq_a), int'(e.fail_qual));
        checkOutput("a_fail_consec", int'(fc_a), int'(e.fail_consec));
        checkOutput("a_ovf", int'(ovf_a), int'(e.ovf));
      end
    end
  end

  always @(negedge clk) begin
    if (done_b) begin
      if (exp_b.size() == 0) begin
        checkOutput("unexpected_done_b", 1, 0);
      end else begin
        exp_t e;
        e = exp_b.pop_front();
        checkOutput("b_count", int'(count_b), e.count);
        checkOutput("b_pass", int'(pass_b), int'(e.pass));
        checkOutput("b_fail_qual", int'(fq_b), int'(e.fail_qual));
        checkOutput("b_fail_consec", int'(fc_b), int'(e.fail_consec));
        checkOutput("b_ovf", int'(ovf_b), int'(e.ovf));
      end
    end
  end

  initial begin
    rst = 1'b1; win = 1'b0; evt = 1'b0; qual = 1'b1;
    idle(2);
    checkOutput("rst_busy", int'(busy_a), 0);
    checkOutput("rst_done", int'(done_a), 0);
    checkOutput("rst_count", int'(count_a), 0);
    checkOutput("rst_ovf", int'(ovf_a), 0);
    rst = 1'b0;
    idle(2);

    $display("[TB] basic window");
    runWindow(12, 32'h0000_02A0, 32'h0, mk(3, 1, 0, 0, 0), mk(3, 1, 0, 0, 0));
    idle(3);
    checkOutput("hold_count_a", int'(count_a), 3);
    checkOutput("idle_busy_a", int'(busy_a), 0);

    $display("[TB] events during delay ignored");
    runWindow(12, 32'h0000_02AC, 32'h0, mk(3, 1, 0, 0, 0), mk(3, 1, 0, 0, 0));
    idle(2);

    $display("[TB] qualifier drop");
    runWindow(12, 32'h0000_02A0, 32'h0000_0100, mk(3, 0, 1, 0, 0), mk(3, 0, 1, 0, 0));
    idle(2);

    $display("[TB] consecutive events");
    runWindow(12, 32'h0000_0260, 32'h0,
              mk(3, !CONSEC_EN, 0, CONSEC_EN, 0), mk(3, !CONSEC_EN, 0, CONSEC_EN, 0));
    idle(2);

    $display("[TB] saturation");
    runWindow(16, 32'h0000_2AA0, 32'h0, mk(5, 0, 0, 0, 0), mk(3, 1, 0, 0, 1));
    idle(3);
    checkOutput("hold_count_a_sat", int'(count_a), 5);
    checkOutput("hold_count_b_sat", int'(count_b), 3);

    $display("[TB] back-to-back windows");
    runWindow(12, 32'h0000_02A0, 32'h0, mk(3, 1, 0, 0, 0), mk(3, 1, 0, 0, 1));
    runWindow(10, 32'h0000_00A0, 32'h0, mk(2, 0, 0, 0, 0), mk(2, 0, 0, 0, 1));
    idle(2);

    $display("[TB] reset mid-window");
    for (int c = 1; c <= 7; c++) applyStimulus(1'b1, (c == 5), 1'b1);
    checkOutput("mid_busy_a", int'(busy_a), 1);
    checkOutput("mid_count_a", int'(count_a), 1);
    rst = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("mrst_busy_a", int'(busy_a), 0);
    checkOutput("mrst_count_a", int'(count_a), 0);
    checkOutput("mrst_done_a", int'(done_a), 0);
    checkOutput("mrst_pass_a", int'(pass_a), 0);
    checkOutput("mrst_fq_a", int'(fq_a), 0);
    checkOutput("mrst_fc_a", int'(fc_a), 0);
    checkOutput("mrst_ovf_b", int'(ovf_b), 0);
    rst = 1'b0;
    idle(3);

    $display("[TB] window after reset");
    runWindow(12, 32'h0000_02A0, 32'h0, mk(3, 1, 0, 0, 0), mk(3, 1, 0, 0, 0));
    idle(3);

    checkOutput("pending_a", exp_a.size(), 0);
    checkOutput("pending_b", exp_b.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rep_window_checker.md
REP_WINDOW_CHECKER -- requirements
Module: rep_window_checker

Interface
REQ-001 SHALL have parameter CNT_W, default 4, width of event counter.
REQ-002 SHALL have parameter EXP_CNT, default 3, required event count per window.
REQ-003 SHALL have parameter START_DLY, default 2, cycles after window open before counting starts (0..15).
REQ-004 SHALL have port clk  input  1  single clock; all logic on posedge clk.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port win  input  1  window signal; rising edge opens, falling edge closes.
REQ-007 SHALL have port evt  input  1  event; each sampled-high cycle in COUNT is one occurrence.
REQ-008 SHALL have port qual  input  1  qualifier; must stay high every cycle from open until close.
REQ-009 SHALL have port busy  output  1  high in DELAY or COUNT.
REQ-010 SHALL have port count  output  CNT_W  occurrences counted in current/last window.
REQ-011 SHALL have port done  output  1  one-cycle pulse when the window result is valid.
REQ-012 SHALL have port pass  output  1  valid with done; count==EXP_CNT and no fail flag.
REQ-013 SHALL have port fail_qual  output  1  valid with done; qual seen low inside window.
REQ-014 SHALL have port fail_consec  output  1  valid with done; consecutive evt seen (see REQ-028).
REQ-015 SHALL have port ovf  output  1  sticky; count saturated in any window since reset.

Function
REQ-016 SHALL implement FSM states IDLE, DELAY, COUNT, REPORT.
REQ-017 SHALL detect open as win==1 with registered win_q==0; close as win==0 with win_q==1.
REQ-018 IDLE: on open, SHALL clear count and flags, load delay counter with START_DLY, go to DELAY (or COUNT if START_DLY==0).
REQ-019 DELAY: SHALL ignore evt, decrement delay counter, go to COUNT when it reaches 1.
REQ-020 COUNT: SHALL increment count on each cycle evt==1, saturating at 2**CNT_W-1 and setting ovf.
REQ-021 DELAY/COUNT: qual==0 in any cycle SHALL set fail_qual for this window.
REQ-022 Close in DELAY or COUNT SHALL go to REPORT; evt in the close cycle is not counted.
REQ-023 REPORT lasts exactly one cycle with done=1; pass/fail_* valid only while done=1.
REQ-024 Open sampled in REPORT SHALL go directly to DELAY/COUNT (back-to-back windows, no lost open).
REQ-025 count SHALL hold its final value from REPORT until the next open.
REQ-026 Close with no prior open (IDLE) SHALL be ignored; open while busy is impossible (win is high).

Reset
REQ-027 rst SHALL force IDLE, win_q=0, count=0, busy=0, done=0, pass=0, fail_qual=0, fail_consec=0, ovf=0; rst mid-window SHALL abandon it with no done pulse.

Configuration
REQ-028 With REP_WIN_CONSEC_CHK_EN defined, evt==1 in two consecutive COUNT cycles SHALL set fail_consec and force pass=0; without it, fail_consec SHALL be tied 0 and consecutive events count normally.

Structure
REQ-029 Package rep_win_pkg SHALL hold the state enum (rep_win_state_t) and a result struct (pass, fail_qual, fail_consec).
REQ-030 Sub-module rep_edge_det SHALL register win and produce rise/fall pulses; all other logic in rep_window_checker.

Verification
REQ-031 Defaults; win rises at cycle 1 (qual=1), evt high cycles 5,7,9, win falls cycle 12 -> done at cycle 13, count=3, pass=1.
REQ-032 As REQ-031 plus evt high at cycles 2,3 (DELAY) -> count=3, pass=1.
REQ-033 As REQ-031 with qual=0 at cycle 8 -> done, fail_qual=1, pass=0, count=3.
REQ-034 With REP_WIN_CONSEC_CHK_EN, evt high cycles 5,6,9 -> count=3, fail_consec=1, pass=0; without it -> pass=1.
REQ-035 CNT_W=2, evt high 5 non-consecutive COUNT cycles -> count=3 (saturated), ovf=1, stays 1 after next window.
REQ-036 win falls cycle 12, rises cycle 13 -> done at 13, second window counts normally; rst at cycle 8 of a window -> no done, all outputs 0.
